// File: rtl/booth_mult_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// partial-product selections and the Booth triplet decoder.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } sel_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}; digit value = -2*t[2] + t[1] + t[0].
    function automatic sel_t booth_decode(input logic [2:0] t);
        sel_t s;
        case (t)
            3'b001, 3'b010: s = PM;
            3'b011:         s = P2M;
            3'b100:         s = N2M;
            3'b101, 3'b110: s = NM;
            default:        s = ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/brent_kung_adder.sv
// Combinational W-bit adder (a + b + cin) built on a Brent-Kung prefix tree.
// Works for any W >= 2, not only powers of two.
module brent_kung_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    localparam int L = $clog2(W);

    logic [W-1:0] p0;
    logic [W-1:0] g;
    logic [W-1:0] p;

    always_comb begin
        p0 = a ^ b;
        g  = a & b;
        p  = p0;
        // Fold cin into bit 0 so every group generate already includes it.
        g[0] = g[0] | (p0[0] & cin);
        for (int d = 0; d < L; d++) begin
            for (int i = 0; i < W; i++) begin
                if (((i + 1) % (1 << (d + 1))) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << d)]);
                    p[i] = p[i] & p[i - (1 << d)];
                end
            end
        end
        for (int d = L - 2; d >= 0; d--) begin
            for (int i = 0; i < W; i++) begin
                if ((((i + 1) % (1 << (d + 1))) == (1 << d)) && (i >= (1 << (d + 1)))) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << d)]);
                    p[i] = p[i] & p[i - (1 << d)];
                end
            end
        end
        sum = p0 ^ {g[W-2:0], cin};
    end

endmodule

// File: rtl/booth_radix4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, WIDTH/2+1 clocks
// per product, valid/ready on both sides, no overlap between consecutive products.
module booth_radix4_seq_mult
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NITER = WIDTH / 2 + 1;
    localparam int EW    = WIDTH + 2;
    localparam int AW    = 2 * WIDTH + 2;
    localparam int CW    = $clog2(NITER + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [EW-1:0]   mcand;
    logic [EW:0]     mplier;
    logic [AW-1:0]   acc;
    logic            last;

    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;
    sel_t            sel;
    logic [AW-1:0]   m_ext;
    logic [AW-1:0]   mult;
    logic [AW-1:0]   shifted;
    logic [AW-1:0]   addend;
    logic            cin;
    logic [AW-1:0]   sum;

    assign last  = (cnt == CW'(NITER - 1));
    assign a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The accumulator is never shifted; the selected multiple is shifted left
    // by 2*cnt instead, so the full-width adder sees the aligned partial product.
    always_comb begin
        sel     = booth_decode(mplier[2:0]);
        m_ext   = {{(AW - EW){mcand[EW-1]}}, mcand};
        mult    = ((sel == P2M) || (sel == N2M)) ? (m_ext << 1) : m_ext;
        shifted = mult << {cnt, 1'b0};
        addend  = '0;
        cin     = 1'b0;
        case (sel)
            PM, P2M: addend = shifted;
            NM, N2M: begin
                addend = ~shifted;
                cin    = 1'b1;
            end
            default: addend = '0;
        endcase
    end

    brent_kung_adder #(
        .W (AW)
    ) u_adder (
        .a   (acc),
        .b   (addend),
        .cin (cin),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= a_ext;
                        mplier <= {b_ext, 1'b0};
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= sum;
                    mplier <= {{2{mplier[EW]}}, mplier[EW:2]};
                    cnt    <= cnt + 1'b1;
                    if (last) product <= sum[2*WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule
